// File: rtl/ahb_lite_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_master
//   AHB-Lite initiator for the LSU. Each accepted load/store becomes one
//   SINGLE/NONSEQ transfer. Only one transfer is in flight at a time.
//   Alignment is checked when the request is accepted. Byte lanes are
//   replicated for stores and steered for loads. Address- and data-phase
//   wait states are honoured, as is the two-cycle ERROR response.
//
// Ports
//   hclk, hresetn        AHB clock; asynchronous active-low reset
//   req_valid_i/ready_o  LSU request handshake (accept on valid && ready)
//   req_write_i          1 = store, 0 = load
//   req_size_i           0 = byte, 1 = halfword, 2 = word
//   req_addr_i           byte address
//   req_wdata_i          right-aligned store data
//   rsp_valid_o          one-cycle completion pulse (no back-pressure)
//   rsp_err_o            completion carries an error
//   rsp_rdata_o          right-aligned, zero-extended load data
//   h*_o / h*_i          AHB-Lite manager signals
//
// DWIDTH must be 32.
// ---------------------------------------------------------------------------
module ahb_lite_master #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  // LSU request
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [2:0]        req_size_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  // LSU response
  output logic              rsp_valid_o,
  output logic              rsp_err_o,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  // AHB-Lite manager
  output logic [AWIDTH-1:0] haddr_o,
  output logic [1:0]        htrans_o,
  output logic              hwrite_o,
  output logic [2:0]        hsize_o,
  output logic [2:0]        hburst_o,
  output logic [3:0]        hprot_o,
  output logic              hmastlock_o,
  output logic [DWIDTH-1:0] hwdata_o,
  input  logic              hready_i,
  input  logic              hresp_i,
  input  logic [DWIDTH-1:0] hrdata_i
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                w_accept;
  logic                w_misaligned;

  // Latched request. It drives the address phase and holds through the
  // data phase.
  logic                r_write;
  logic [2:0]          r_size;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_hwdata;

  // Completion registers. They are presented while the FSM sits in RESP.
  logic                r_rsp_err;
  logic [DWIDTH-1:0]   r_rsp_rdata;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  function automatic logic is_misaligned(input logic [2:0] size,
                                         input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (size)
      3'd0:    bad = 1'b0;
      3'd1:    bad = lane[0];
      3'd2:    bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Put the store data on every lane it could occupy. The slave then
  // picks its lanes from haddr and hsize without further muxing.
  function automatic logic [DWIDTH-1:0] replicate(input logic [2:0]        size,
                                                  input logic [DWIDTH-1:0] data);
    logic [DWIDTH-1:0] rep;
    rep = data;
    case (size)
      3'd0:    rep = {(DWIDTH/8){data[7:0]}};
      3'd1:    rep = {(DWIDTH/16){data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

  // Bring the addressed lane down to bit 0 and zero-extend it.
  function automatic logic [DWIDTH-1:0] steer(input logic [2:0]        size,
                                              input logic [1:0]        lane,
                                              input logic [DWIDTH-1:0] data);
    logic [DWIDTH-1:0] shifted;
    logic [DWIDTH-1:0] result;
    shifted = '0;
    result  = data;
    case (size)
      3'd0: begin
        shifted = data >> {lane, 3'b000};
        result  = {{(DWIDTH-8){1'b0}}, shifted[7:0]};
      end
      3'd1: begin
        shifted = data >> {lane[1], 4'b0000};
        result  = {{(DWIDTH-16){1'b0}}, shifted[15:0]};
      end
      default: result = data;
    endcase
    return result;
  endfunction

  assign w_accept     = req_valid_i && req_ready_o;
  assign w_misaligned = is_misaligned(req_size_i, req_addr_i[1:0]);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: the reset is in the sensitivity list so that hresetn clears the
  // state at once, mid-transfer included, without waiting for an hclk edge.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop then
      // samples pre-edge values, whatever order the processes are evaluated in.
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: assign a default first. With that, no path through the case
    // leaves w_next_state unassigned, and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_accept) begin
          w_next_state = w_misaligned ? ST_RESP : ST_ADDR;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ADDR: if (hready_i) w_next_state = ST_DATA;
      // The first ERROR cycle has hready_i low, so it waits here like any
      // other wait state.
      ST_DATA: if (hready_i) w_next_state = ST_RESP;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs decoded from state only
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    htrans_o    = HTRANS_IDLE;
    case (r_state)
      ST_IDLE: req_ready_o = 1'b1;
      ST_ADDR: htrans_o    = HTRANS_NONSEQ;
      ST_DATA: ;
      ST_RESP: begin
        req_ready_o = 1'b1;
        rsp_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Request latch and completion capture
  // -------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_write     <= 1'b0;
      r_size      <= 3'd0;
      r_addr      <= '0;
      r_hwdata    <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (w_accept) begin
      r_write  <= req_write_i;
      r_size   <= req_size_i;
      r_addr   <= req_addr_i;
      r_hwdata <= replicate(req_size_i, req_wdata_i);
      // A misaligned request completes next cycle without touching the bus.
      // Its response is therefore fixed here.
      if (w_misaligned) begin
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= '0;
      end
    end else if (r_state == ST_DATA && hready_i) begin
      r_rsp_err   <= hresp_i;
      r_rsp_rdata <= (!r_write && !hresp_i) ? steer(r_size, r_addr[1:0], hrdata_i)
                                            : '0;
    end
  end

  assign haddr_o     = r_addr;
  assign hwrite_o    = r_write;
  assign hsize_o     = r_size;
  assign hwdata_o    = r_hwdata;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_rdata_o = r_rsp_rdata;

  assign hburst_o    = 3'b000;
  assign hprot_o     = 4'b0011;
  assign hmastlock_o = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_master
//   Directed bench for ahb_lite_master. The stimulus process drives the LSU
//   side and plays the AHB slave cycle by cycle. Each expected completion is
//   queued when its request is issued. A separate monitor pops and compares
//   whenever rsp_valid_o is seen. Bus-side expectations are checked inline,
//   1 time unit after each posedge.
// ---------------------------------------------------------------------------
module tb_ahb_lite_master;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [2:0]  req_size_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [2:0]  hsize_o;
  logic [2:0]  hburst_o;
  logic [3:0]  hprot_o;
  logic        hmastlock_o;
  logic [31:0] hwdata_o;
  logic        hready_i;
  logic        hresp_i;
  logic [31:0] hrdata_i;

  int   n_checks = 0;
  int   n_errors = 0;
  rsp_t exp_q[$];

  always #5 hclk = ~hclk;

  ahb_lite_master #(.AWIDTH(32), .DWIDTH(32)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_size_i  (req_size_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_rdata_o (rsp_rdata_o),
    .haddr_o     (haddr_o),
    .htrans_o    (htrans_o),
    .hwrite_o    (hwrite_o),
    .hsize_o     (hsize_o),
    .hburst_o    (hburst_o),
    .hprot_o     (hprot_o),
    .hmastlock_o (hmastlock_o),
    .hwdata_o    (hwdata_o),
    .hready_i    (hready_i),
    .hresp_i     (hresp_i),
    .hrdata_i    (hrdata_i)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [2:0] sz,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_size_i  = sz;
    req_addr_i  = addr;
    req_wdata_i = wdata;
  endtask

  // Zero-wait-state transfer. Checks the 3-cycle timing on the bus side and
  // queues the expected completion for the monitor.
  task automatic xfer(input string tag, input logic wr, input logic [2:0] sz,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_hwdata, input rsp_t exp);
    issue(wr, sz, addr, wdata);
    exp_q.push_back(exp);
    tick();                                     // cycle 1: ADDR
    req_valid_i = 1'b0;
    check({tag, " htrans_c1"}, 32'(htrans_o), 32'h2);
    check({tag, " haddr_c1"},  haddr_o, addr);
    check({tag, " hwrite_c1"}, 32'(hwrite_o), 32'(wr));
    check({tag, " hsize_c1"},  32'(hsize_o), 32'(sz));
    tick();                                     // cycle 2: DATA
    check({tag, " htrans_c2"}, 32'(htrans_o), 32'h0);
    if (wr) check({tag, " hwdata_c2"}, hwdata_o, exp_hwdata);
    tick();                                     // cycle 3: RESP
    check({tag, " rsp_valid_c3"}, 32'(rsp_valid_o), 32'h1);
    tick();                                     // back to IDLE
    check({tag, " rsp_valid_c4"}, 32'(rsp_valid_o), 32'h0);
  endtask

  // Monitor. Every completion pulse is compared with the oldest expectation.
  always @(negedge hclk) begin
    if (hresetn === 1'b1 && rsp_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got err=%b rdata=%h expected no response",
                 rsp_err_o, rsp_rdata_o);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_err",   32'(rsp_err_o), 32'(e.err));
        check("rsp_rdata", rsp_rdata_o,    e.rdata);
      end
    end
  end

  initial begin
    hresetn     = 1'b0;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_size_i  = 3'd0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    hready_i    = 1'b1;
    hresp_i     = 1'b0;
    hrdata_i    = 32'hAABB_CCDD;

    // Reset values
    #2;
    check("rst req_ready",  32'(req_ready_o), 32'h1);
    check("rst rsp_valid",  32'(rsp_valid_o), 32'h0);
    check("rst rsp_err",    32'(rsp_err_o),   32'h0);
    check("rst rsp_rdata",  rsp_rdata_o,      32'h0);
    check("rst htrans",     32'(htrans_o),    32'h0);
    check("rst haddr",      haddr_o,          32'h0);
    check("rst hwrite",     32'(hwrite_o),    32'h0);
    check("rst hsize",      32'(hsize_o),     32'h0);
    check("rst hwdata",     hwdata_o,         32'h0);
    check("const hburst",   32'(hburst_o),    32'h0);
    check("const hprot",    32'(hprot_o),     32'h3);
    check("const hmastlock", 32'(hmastlock_o), 32'h0);
    tick();
    tick();
    hresetn = 1'b1;
    tick();

    // Zero-wait-state transfers
    xfer("word_store", 1'b1, 3'd2, 32'h1000_0008, 32'h0000_00FF,
         32'h0000_00FF, '{err: 1'b0, rdata: 32'h0});
    xfer("byte_load",  1'b0, 3'd0, 32'h1000_0005, 32'h0,
         32'h0, '{err: 1'b0, rdata: 32'h0000_00CC});
    xfer("byte_store", 1'b1, 3'd0, 32'h1000_0005, 32'h0000_005A,
         32'h5A5A_5A5A, '{err: 1'b0, rdata: 32'h0});
    xfer("half_load",  1'b0, 3'd1, 32'h1000_0006, 32'h0,
         32'h0, '{err: 1'b0, rdata: 32'h0000_AABB});
    xfer("byte_load3", 1'b0, 3'd0, 32'h1000_0003, 32'h0,
         32'h0, '{err: 1'b0, rdata: 32'h0000_00AA});
    xfer("word_load",  1'b0, 3'd2, 32'h1000_000C, 32'h0,
         32'h0, '{err: 1'b0, rdata: 32'hAABB_CCDD});

    // Wait states: 2 in ADDR and 3 in DATA; the response lands in cycle 8
    issue(1'b1, 3'd1, 32'h1000_0002, 32'h0000_1234);
    exp_q.push_back('{err: 1'b0, rdata: 32'h0});
    tick();
    req_valid_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      hready_i = !(c == 1 || c == 2 || c == 4 || c == 5 || c == 6);
      if (c <= 3) begin
        check($sformatf("ws htrans_c%0d", c), 32'(htrans_o), 32'h2);
        check($sformatf("ws haddr_c%0d", c),  haddr_o, 32'h1000_0002);
      end else if (c <= 7) begin
        check($sformatf("ws htrans_c%0d", c), 32'(htrans_o), 32'h0);
        check($sformatf("ws hwdata_c%0d", c), hwdata_o, 32'h1234_1234);
      end
      check($sformatf("ws rsp_valid_c%0d", c), 32'(rsp_valid_o), 32'(c == 8));
      tick();
    end
    hready_i = 1'b1;

    // Two-cycle ERROR response on a load
    hrdata_i = 32'h1122_3344;
    issue(1'b0, 3'd2, 32'h1000_0010, 32'h0);
    exp_q.push_back('{err: 1'b1, rdata: 32'h0});
    tick();                                     // cycle 1: ADDR
    req_valid_i = 1'b0;
    check("err htrans_c1", 32'(htrans_o), 32'h2);
    tick();                                     // cycle 2: DATA, first ERROR cycle
    hresp_i  = 1'b1;
    hready_i = 1'b0;
    tick();                                     // cycle 3: still DATA
    check("err htrans_c3",    32'(htrans_o),    32'h0);
    check("err rsp_valid_c3", 32'(rsp_valid_o), 32'h0);
    hready_i = 1'b1;                            // second ERROR cycle
    tick();                                     // cycle 4: RESP
    hresp_i = 1'b0;
    check("err rsp_valid_c4", 32'(rsp_valid_o), 32'h1);
    check("err htrans_c4",    32'(htrans_o),    32'h0);
    tick();
    check("err htrans_c5",    32'(htrans_o),    32'h0);
    hrdata_i = 32'hAABB_CCDD;

    // Misaligned requests finish in cycle 1 with no NONSEQ
    issue(1'b0, 3'd2, 32'h1000_0002, 32'h0);
    exp_q.push_back('{err: 1'b1, rdata: 32'h0});
    tick();
    req_valid_i = 1'b0;
    check("mis_word htrans",    32'(htrans_o),    32'h0);
    check("mis_word rsp_valid", 32'(rsp_valid_o), 32'h1);
    tick();
    check("mis_word htrans_c2", 32'(htrans_o),    32'h0);
    issue(1'b0, 3'd1, 32'h1000_0001, 32'h0);
    exp_q.push_back('{err: 1'b1, rdata: 32'h0});
    tick();
    req_valid_i = 1'b0;
    check("mis_half htrans",    32'(htrans_o),    32'h0);
    check("mis_half rsp_valid", 32'(rsp_valid_o), 32'h1);
    tick();
    issue(1'b0, 3'd3, 32'h1000_0000, 32'h0);
    exp_q.push_back('{err: 1'b1, rdata: 32'h0});
    tick();
    req_valid_i = 1'b0;
    check("mis_size3 htrans",    32'(htrans_o),    32'h0);
    check("mis_size3 rsp_valid", 32'(rsp_valid_o), 32'h1);
    tick();

    // Back-to-back: a second request is accepted in RESP. Reset then hits
    // during its data phase.
    issue(1'b0, 3'd2, 32'h1000_0020, 32'h0);
    exp_q.push_back('{err: 1'b0, rdata: 32'hAABB_CCDD});
    tick();                                     // cycle 1: ADDR
    req_valid_i = 1'b0;
    tick();                                     // cycle 2: DATA
    tick();                                     // cycle 3: RESP
    check("b2b ready_in_resp", 32'(req_ready_o), 32'h1);
    issue(1'b1, 3'd2, 32'h1000_0024, 32'hDEAD_BEEF);
    tick();                                     // cycle 4: ADDR of the second
    req_valid_i = 1'b0;
    check("b2b htrans_c4", 32'(htrans_o), 32'h2);
    check("b2b haddr_c4",  haddr_o, 32'h1000_0024);
    tick();                                     // cycle 5: DATA of the second
    check("b2b hwdata_c5", hwdata_o, 32'hDEAD_BEEF);
    hresetn = 1'b0;
    #1;
    check("arst req_ready", 32'(req_ready_o), 32'h1);
    check("arst rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("arst htrans",    32'(htrans_o),    32'h0);
    check("arst haddr",     haddr_o,          32'h0);
    check("arst hwrite",    32'(hwrite_o),    32'h0);
    check("arst hsize",     32'(hsize_o),     32'h0);
    check("arst hwdata",    hwdata_o,         32'h0);
    check("arst rsp_err",   32'(rsp_err_o),   32'h0);
    tick();
    tick();
    hresetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("post_rst ready_%0d", c),  32'(req_ready_o), 32'h1);
      check($sformatf("post_rst htrans_%0d", c), 32'(htrans_o),    32'h0);
      tick();
    end

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
